// File: rtl/fetch_stage_pkg.sv
// Shared constants and FSM encoding for the RV64 instruction-fetch stage.
package fetch_stage_pkg;

    localparam int XLEN = 64;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/grant + read-data handshake between fetch and imem.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [31:0]     rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/fetch_perf_counters.sv
// Delivered-instruction and decode-stall cycle counters; both wrap at 2^32.
module fetch_perf_counters
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic        id_stall,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
);

    logic [31:0] fetched_q, fetched_d;
    logic [31:0] stall_q, stall_d;

    always_comb begin
        fetched_d = fetched_q;
        stall_d   = stall_q;
        if (if_valid && !id_stall) fetched_d = fetched_q + 32'd1;
        if (if_valid && id_stall)  stall_d   = stall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q <= '0;
            stall_q   <= '0;
        end else begin
            fetched_q <= fetched_d;
            stall_q   <= stall_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;

endmodule

// File: rtl/fetch_stage.sv
// RV64 fetch stage: PC, one-outstanding imem request FSM, 1-entry hold buffer, redirect kill.
// Optional perf counters are enabled by defining FETCH_PERF_COUNTERS_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_target,
    input  logic              id_stall,
    fetch_stage_if.master     imem,
    output logic              if_valid,
    output logic [XLEN-1:0]   if_pc,
    output logic [31:0]       if_instr
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic            imem_req_q, imem_req_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [31:0]     hold_instr_q, hold_instr_d;
    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [31:0]     if_instr_q, if_instr_d;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;

        // Decode took the current word; a load below re-raises valid.
        if (if_valid_q && !id_stall) if_valid_d = 1'b0;

        case (state_q)
            IDLE: state_d = REQ;
            REQ:  if (imem.gnt) state_d = WAIT;
            WAIT: begin
                if (imem.rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else if (!if_valid_q || !id_stall) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_q;
                        if_instr_d = imem.rdata;
                        pc_d       = pc_q + PC_STEP;
                        state_d    = REQ;
                    end else begin
                        hold_pc_d    = pc_q;
                        hold_instr_d = imem.rdata;
                        pc_d         = pc_q + PC_STEP;
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!id_stall) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = hold_pc_q;
                    if_instr_d = hold_instr_q;
                    state_d    = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // A taken branch wins over everything, including decode back-pressure.
        if (redirect_valid) begin
            pc_d       = redirect_target & ALIGN_MASK;
            if_valid_d = 1'b0;
            case (state_q)
                REQ:  if (imem.gnt) kill_d = 1'b1;
                WAIT: begin
                    if (imem.rvalid) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end
                HOLD: state_d = REQ;
                default: ;
            endcase
        end

        imem_req_d = (state_d == REQ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            imem_req_q   <= 1'b0;
            hold_pc_q    <= '0;
            hold_instr_q <= NOP_INSTR;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            if_instr_q   <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            imem_req_q   <= imem_req_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
        end
    end

    assign imem.req  = imem_req_q;
    assign imem.addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;

`ifdef FETCH_PERF_COUNTERS_EN
    fetch_perf_counters u_perf (
        .clk          (clk),
        .reset        (reset),
        .if_valid     (if_valid_q),
        .id_stall     (id_stall),
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
    );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle table for streaming/stall, hand sequences for redirect/reset.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic            clk;
    logic            reset;
    logic            redirect_valid;
    logic [63:0]     redirect_target;
    logic            id_stall;
    logic            if_valid;
    logic [63:0]     if_pc;
    logic [31:0]     if_instr;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0]     perf_fetched;
    logic [31:0]     perf_stall;
`endif

    fetch_stage_if imem_bus ();

    fetch_stage #(.RESET_PC(64'h0)) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .id_stall        (id_stall),
        .imem            (imem_bus),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_instr        (if_instr)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_stall      (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        stall;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_valid;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] dw(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic vec_t mk(input logic stall, input logic gnt, input logic rv,
                                input logic [31:0] rdata, input logic e_req,
                                input logic [63:0] e_addr, input logic e_valid,
                                input logic [63:0] e_pc, input logic [31:0] e_instr);
        vec_t v;
        v.stall = stall; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_pc = e_pc; v.e_instr = e_instr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input logic redir, input logic [63:0] tgt, input logic stall,
                        input logic gnt, input logic rv, input logic [31:0] rdata);
        redirect_valid   = redir;
        redirect_target  = tgt;
        id_stall         = stall;
        imem_bus.gnt     = gnt;
        imem_bus.rvalid  = rv;
        imem_bus.rdata   = rdata;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        id_stall        = 1'b0;
        imem_bus.gnt    = 1'b0;
        imem_bus.rvalid = 1'b0;
        imem_bus.rdata  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Cycle table after reset release: stream 0,4,8 then stall 5 cycles with pc=8 on the outputs.
        vecs.push_back(mk(0,0,0,32'h0,      0,64'd0, 0,64'd0, NOP_INSTR));
        vecs.push_back(mk(0,1,0,32'h0,      1,64'd0, 0,64'd0, NOP_INSTR));
        vecs.push_back(mk(0,0,1,dw(64'd0),  0,64'd0, 0,64'd0, NOP_INSTR));
        vecs.push_back(mk(0,1,0,32'h0,      1,64'd4, 1,64'd0, dw(64'd0)));
        vecs.push_back(mk(0,0,1,dw(64'd4),  0,64'd4, 0,64'd0, dw(64'd0)));
        vecs.push_back(mk(0,1,0,32'h0,      1,64'd8, 1,64'd4, dw(64'd4)));
        vecs.push_back(mk(0,0,1,dw(64'd8),  0,64'd8, 0,64'd4, dw(64'd4)));
        vecs.push_back(mk(1,1,0,32'h0,      1,64'd12,1,64'd8, dw(64'd8)));
        vecs.push_back(mk(1,0,1,dw(64'd12), 0,64'd12,1,64'd8, dw(64'd8)));
        vecs.push_back(mk(1,0,0,32'h0,      0,64'd16,1,64'd8, dw(64'd8)));
        vecs.push_back(mk(1,0,0,32'h0,      0,64'd16,1,64'd8, dw(64'd8)));
        vecs.push_back(mk(1,0,0,32'h0,      0,64'd16,1,64'd8, dw(64'd8)));
        vecs.push_back(mk(0,0,0,32'h0,      0,64'd16,1,64'd8, dw(64'd8)));
        vecs.push_back(mk(0,1,0,32'h0,      1,64'd16,1,64'd12,dw(64'd12)));
        vecs.push_back(mk(0,0,1,dw(64'd16), 0,64'd16,0,64'd12,dw(64'd12)));
        vecs.push_back(mk(0,0,0,32'h0,      1,64'd20,1,64'd16,dw(64'd16)));
        vecs.push_back(mk(0,0,0,32'h0,      1,64'd20,0,64'd16,dw(64'd16)));

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            chk($sformatf("v%0d_req", i),   imem_bus.req,  vecs[i].e_req);
            chk($sformatf("v%0d_addr", i),  imem_bus.addr, vecs[i].e_addr);
            chk($sformatf("v%0d_valid", i), if_valid,      vecs[i].e_valid);
            chk($sformatf("v%0d_pc", i),    if_pc,         vecs[i].e_pc);
            chk($sformatf("v%0d_instr", i), if_instr,      vecs[i].e_instr);
            $display("[TB] vec %0d req=%b addr=%h valid=%b pc=%h instr=%h",
                     i, imem_bus.req, imem_bus.addr, if_valid, if_pc, if_instr);
            tick(0, 64'h0, vecs[i].stall, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
        end

        // Redirect while waiting; stale word arrives 3 cycles later and must be dropped.
        do_reset();
        tick(0, 0, 0, 0, 0, 0);
        chk("rw_req", imem_bus.req, 1'b1);
        tick(0, 0, 0, 1, 0, 0);
        tick(1, 64'h100, 0, 0, 0, 0);
        chk("rw_req_wait", imem_bus.req, 1'b0);
        chk("rw_valid_a", if_valid, 1'b0);
        tick(0, 0, 0, 0, 0, 0);
        chk("rw_valid_b", if_valid, 1'b0);
        tick(0, 0, 0, 0, 0, 0);
        chk("rw_valid_c", if_valid, 1'b0);
        tick(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("rw_req_tgt", imem_bus.req, 1'b1);
        chk("rw_addr_tgt", imem_bus.addr, 64'h100);
        chk("rw_valid_d", if_valid, 1'b0);
        tick(0, 0, 0, 1, 0, 0);
        chk("rw_valid_e", if_valid, 1'b0);
        tick(0, 0, 0, 0, 1, dw(64'h100));
        chk("rw_valid_f", if_valid, 1'b1);
        chk("rw_pc", if_pc, 64'h100);
        chk("rw_instr", if_instr, dw(64'h100));
        chk("rw_addr_next", imem_bus.addr, 64'h104);
        $display("[TB] redirect-in-wait pc=%h instr=%h", if_pc, if_instr);

        // Redirect in the same cycle as rvalid; misaligned target is forced to a word.
        do_reset();
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 0, 0);
        tick(1, 64'h203, 0, 0, 1, 32'hBAD0_0001);
        chk("rr_req", imem_bus.req, 1'b1);
        chk("rr_addr", imem_bus.addr, 64'h200);
        chk("rr_valid_a", if_valid, 1'b0);
        tick(0, 0, 0, 1, 0, 0);
        chk("rr_valid_b", if_valid, 1'b0);
        tick(0, 0, 0, 0, 1, dw(64'h200));
        chk("rr_valid_c", if_valid, 1'b1);
        chk("rr_pc", if_pc, 64'h200);
        chk("rr_instr", if_instr, dw(64'h200));
        $display("[TB] redirect-with-rvalid pc=%h instr=%h", if_pc, if_instr);

        // Redirect in the same cycle as gnt: outstanding word is killed.
        do_reset();
        tick(0, 0, 0, 0, 0, 0);
        tick(1, 64'h103, 0, 1, 0, 0);
        chk("rg_req_wait", imem_bus.req, 1'b0);
        chk("rg_valid_a", if_valid, 1'b0);
        tick(0, 0, 0, 0, 1, 32'hBAD0_0002);
        chk("rg_req", imem_bus.req, 1'b1);
        chk("rg_addr", imem_bus.addr, 64'h100);
        chk("rg_valid_b", if_valid, 1'b0);
        tick(0, 0, 0, 1, 0, 0);
        chk("rg_valid_c", if_valid, 1'b0);
        tick(0, 0, 0, 0, 1, dw(64'h100));
        chk("rg_valid_d", if_valid, 1'b1);
        chk("rg_pc", if_pc, 64'h100);
        chk("rg_instr", if_instr, dw(64'h100));
        $display("[TB] redirect-with-gnt pc=%h instr=%h", if_pc, if_instr);

        // Reset in WAIT, then a late rvalid arrives in IDLE and is ignored.
        do_reset();
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 0, 0);
        reset = 1'b1;
        tick(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        chk("rs_req_idle", imem_bus.req, 1'b0);
        chk("rs_valid_a", if_valid, 1'b0);
        tick(0, 0, 0, 0, 1, 32'hBAD0_0003);
        chk("rs_req", imem_bus.req, 1'b1);
        chk("rs_addr", imem_bus.addr, 64'h0);
        chk("rs_valid_b", if_valid, 1'b0);
        chk("rs_pc", if_pc, 64'h0);
        chk("rs_instr_nop", if_instr, NOP_INSTR);
        tick(0, 0, 0, 1, 0, 0);
        tick(0, 0, 0, 0, 1, dw(64'h0));
        chk("rs_valid_c", if_valid, 1'b1);
        chk("rs_instr", if_instr, dw(64'h0));
        $display("[TB] reset-in-wait pc=%h instr=%h", if_pc, if_instr);

        // Redirect in REQ without gnt to the top word; the next PC wraps to zero.
        do_reset();
        tick(0, 0, 0, 0, 0, 0);
        tick(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0);
        chk("wr_req", imem_bus.req, 1'b1);
        chk("wr_addr", imem_bus.addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick(0, 0, 0, 1, 0, 0);
        tick(0, 0, 0, 0, 1, dw(64'hFFFF_FFFF_FFFF_FFFC));
        chk("wr_valid", if_valid, 1'b1);
        chk("wr_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wr_addr_wrap", imem_bus.addr, 64'h0);
        $display("[TB] pc-wrap pc=%h next_addr=%h", if_pc, imem_bus.addr);

`ifdef FETCH_PERF_COUNTERS_EN
        // Ten deliveries, then three cycles of decode stall on the last word.
        do_reset();
        chk("pf_fetched_rst", perf_fetched, 32'd0);
        chk("pf_stall_rst", perf_stall, 32'd0);
        tick(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            tick(0, 0, 0, 1, 0, 0);
            tick(0, 0, 0, 0, 1, dw(64'(k * 4)));
        end
        repeat (3) tick(0, 0, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        chk("pf_fetched", perf_fetched, 32'd10);
        chk("pf_stall", perf_stall, 32'd3);
        $display("[TB] perf fetched=%0d stall=%0d", perf_fetched, perf_stall);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
